// File: rtl/ibex_prefetch_buffer_n.sv
// Instruction prefetch buffer: up to NUM_REQS outstanding word fetches, FIFO_DEPTH-word output queue,
// branch flush with count-based discard of in-flight responses, optional stop-on-error.
`timescale 1ns/1ps
module ibex_prefetch_buffer_n #(
  parameter int unsigned NUM_REQS    = 2,
  parameter int unsigned FIFO_DEPTH  = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          STOP_ON_ERR = 1'b0,
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic              instr_req_o,
  input  logic              instr_gnt_i,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic [31:0]       instr_rdata_i,
  input  logic              instr_err_i,
  input  logic              instr_rvalid_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

  logic [ADDR_W-1:0] r_fetch_addr;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [ADDR_W-1:0] r_pc_tag;
  logic              r_pend;
  logic              r_pend_disc;
  logic              r_err_stop;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [CNT_W-1:0]  r_disc_cnt;
  logic [OCC_W-1:0]  r_occ;
  logic [31:0]       r_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_pc   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_err;

  logic [ADDR_W-1:0] w_branch_addr;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [OCC_W-1:0]  w_occ_eff;
  logic [31:0]       w_live;
  logic              w_issue;
  logic              w_gnt;
  logic              w_stale_gnt;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_out_next;
  logic [CNT_W-1:0]  w_disc_next;
  logic [OCC_W-1:0]  w_wr_idx;
  logic [31:0]       w_data_nxt [FIFO_DEPTH];
  logic [ADDR_W-1:0] w_pc_nxt   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] w_err_nxt;

  assign w_branch_addr = {addr_i[ADDR_W-1:2], 2'b00};
  assign w_issue_addr  = branch_i ? w_branch_addr : r_fetch_addr;

  // Every live (non-discarded) outstanding response already owns a FIFO slot.
  always_comb begin
    w_occ_eff = branch_i ? '0 : r_occ;
    w_live    = 32'(w_occ_eff) + 32'(r_out_cnt) - 32'(r_disc_cnt);
    w_issue   = req_i & ~r_pend & ~r_err_stop &
                (r_out_cnt < CNT_W'(NUM_REQS)) &
                (w_live < 32'(FIFO_DEPTH));
  end

  assign instr_req_o  = r_pend | w_issue;
  assign instr_addr_o = r_pend ? r_pend_addr : w_issue_addr;
  assign w_gnt        = instr_req_o & instr_gnt_i;
  // A held request issued before a redirect belongs to the old stream.
  assign w_stale_gnt  = w_gnt & r_pend & (r_pend_disc | branch_i);
  assign w_push       = instr_rvalid_i & (r_disc_cnt == '0) & ~branch_i;
  assign w_pop        = (r_occ != '0) & ready_i & ~branch_i;

  always_comb begin
    w_out_next = r_out_cnt + CNT_W'(w_gnt) - CNT_W'(instr_rvalid_i);
    if (branch_i) begin
      w_disc_next = r_out_cnt + CNT_W'(w_gnt & r_pend) - CNT_W'(instr_rvalid_i);
    end else begin
      w_disc_next = r_disc_cnt - CNT_W'(instr_rvalid_i & (r_disc_cnt != '0))
                    + CNT_W'(w_stale_gnt);
    end
  end

  always_comb begin
    w_wr_idx = w_pop ? (r_occ - OCC_W'(1)) : r_occ;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      w_data_nxt[i] = r_data[i];
      w_pc_nxt[i]   = r_pc[i];
      w_err_nxt[i]  = r_err[i];
    end
    if (w_pop) begin
      for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
        w_data_nxt[i] = r_data[i+1];
        w_pc_nxt[i]   = r_pc[i+1];
        w_err_nxt[i]  = r_err[i+1];
      end
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (w_push && (w_wr_idx == OCC_W'(i))) begin
        w_data_nxt[i] = instr_rdata_i;
        w_pc_nxt[i]   = r_pc_tag;
        w_err_nxt[i]  = instr_err_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend      <= 1'b0;
      r_pend_disc <= 1'b0;
      r_pend_addr <= '0;
    end else if (w_issue && !instr_gnt_i) begin
      r_pend      <= 1'b1;
      r_pend_disc <= 1'b0;
      r_pend_addr <= w_issue_addr;
    end else if (r_pend && instr_gnt_i) begin
      r_pend      <= 1'b0;
      r_pend_disc <= 1'b0;
    end else if (r_pend && branch_i) begin
      r_pend_disc <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_addr <= '0;
      r_pc_tag     <= '0;
      r_out_cnt    <= '0;
      r_disc_cnt   <= '0;
      r_err_stop   <= 1'b0;
    end else begin
      r_out_cnt  <= w_out_next;
      r_disc_cnt <= w_disc_next;
      if (w_issue) begin
        r_fetch_addr <= w_issue_addr + ADDR_W'(4);
      end else if (branch_i) begin
        r_fetch_addr <= w_branch_addr;
      end
      if (branch_i) begin
        r_pc_tag <= addr_i;
      end else if (w_push) begin
        r_pc_tag <= {r_pc_tag[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
      end
      if (branch_i) begin
        r_err_stop <= 1'b0;
      end else if (STOP_ON_ERR && w_push && instr_err_i) begin
        r_err_stop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_occ <= '0;
      r_err <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      r_occ <= branch_i ? '0 : (r_occ + OCC_W'(w_push) - OCC_W'(w_pop));
      r_err <= w_err_nxt;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= w_data_nxt[i];
        r_pc[i]   <= w_pc_nxt[i];
      end
    end
  end

  assign valid_o     = (r_occ != '0);
  assign rdata_o     = r_data[0];
  assign addr_o      = r_pc[0];
  assign err_o       = r_err[0];
  assign occupancy_o = r_occ;
  assign busy_o      = instr_req_o | (r_out_cnt != '0);

`ifndef SYNTHESIS
  a_rvalid_with_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> (r_out_cnt != '0));
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_push && !w_pop) |-> (r_occ != OCC_W'(FIFO_DEPTH)));
`endif

endmodule

// File: tb/tb_ibex_prefetch_buffer_n.sv
// Scoreboard bench: branch stimulus queues the expected instruction stream; a bus model answers
// fetches from a synthetic memory and a monitor checks every word the consumer accepts.
`timescale 1ns/1ps
module tb_ibex_prefetch_buffer_n;

  localparam int NR  = 2;
  localparam int FD  = 3;
  localparam int AW  = 32;
  localparam bit SOE = 1'b1;
  localparam int OW  = $clog2(FD + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          branch_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic          ready_i = 1'b0;
  logic          valid_o;
  logic [31:0]   rdata_o;
  logic [AW-1:0] addr_o;
  logic          err_o;
  logic [OW-1:0] occupancy_o;
  logic          instr_req_o;
  logic          instr_gnt_i = 1'b0;
  logic [AW-1:0] instr_addr_o;
  logic [31:0]   instr_rdata_i = '0;
  logic          instr_err_i = 1'b0;
  logic          instr_rvalid_i = 1'b0;
  logic          busy_o;

  ibex_prefetch_buffer_n #(.NUM_REQS(NR), .FIFO_DEPTH(FD), .ADDR_W(AW), .STOP_ON_ERR(SOE)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
    .occupancy_o(occupancy_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .instr_rvalid_i(instr_rvalid_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return ((a >> 2) % 23) == 8;
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } exp_t;
  exp_t exp_q[$];

  // bus model state
  int          gnt_pct = 100;
  int          rv_pct  = 100;
  bit          gnt_force_low = 1'b0;
  logic [31:0] oq_addr[$];
  int          oq_epoch[$];
  logic [31:0] grant_log[$];
  int          epoch = 0;
  bit          held = 1'b0;
  logic [31:0] held_addr = '0;
  int          held_birth = 0;

  initial begin
    logic [31:0] a;
    int live;
    @(negedge rst_i);
    forever begin
      @(negedge clk_i);
      live = 0;
      foreach (oq_epoch[k]) if (oq_epoch[k] == epoch) live++;
      chk("reserve", (32'(occupancy_o) + 32'(live)) <= FD, 1);
      chk("occ_bound", 32'(occupancy_o) <= FD, 1);
      chk("valid_vs_occ", valid_o, occupancy_o != '0);
      instr_rvalid_i = 1'b0;
      if (oq_addr.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
        a = oq_addr.pop_front();
        void'(oq_epoch.pop_front());
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(a);
        instr_err_i    = err_fn(a);
      end else begin
        instr_rdata_i = $urandom;
        instr_err_i   = 1'($urandom_range(0, 1));
      end
      instr_gnt_i = !gnt_force_low && ($urandom_range(0, 99) < gnt_pct);
      if (held) chk("req_held", instr_req_o, 1);
      if (instr_req_o) begin
        chk("addr_align", instr_addr_o[1:0], 0);
        if (held) chk("addr_hold", instr_addr_o, held_addr);
        else held_birth = branch_i ? epoch + 1 : epoch;
        if (instr_gnt_i) begin
          oq_addr.push_back(instr_addr_o);
          oq_epoch.push_back(held_birth);
          grant_log.push_back(instr_addr_o);
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_addr = instr_addr_o;
        end
      end
      if (branch_i) epoch++;
      chk("outstanding", oq_addr.size() <= NR, 1);
    end
  end

  // monitor / scoreboard
  initial begin
    int extra;
    bit seg_err;
    exp_t e;
    extra = 0;
    seg_err = 1'b0;
    @(negedge rst_i);
    forever begin
      @(negedge clk_i);
      if (branch_i) begin
        seg_err = 1'b0;
        extra = 0;
      end else if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exp_underflow: got pc %h with no expected word", addr_o);
        end else begin
          e = exp_q.pop_front();
          chk("pc", addr_o, e.pc);
          chk("data", rdata_o, e.data);
          chk("err", err_o, e.err);
          if (seg_err) begin
            extra++;
            chk("stop_extra", extra <= NR, 1);
          end
          if (e.err) seg_err = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    logic [31:0] pc;
    branch_i = 1'b1;
    addr_i   = tgt;
    exp_q.delete();
    for (int k = 0; k < 80; k++) begin
      pc = (k == 0) ? tgt : ({tgt[31:2], 2'b00} + 32'(4 * k));
      exp_q.push_back('{pc: pc, data: mem_word({pc[31:2], 2'b00}), err: err_fn({pc[31:2], 2'b00})});
    end
    step();
    branch_i = 1'b0;
  endtask

  initial begin
    int len;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_req", instr_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_iaddr", instr_addr_o, 0);
    step();
    rst_i = 1'b0;
    repeat (2) step();

    // sequential stream from 0x100
    req_i = 1'b1;
    ready_i = 1'b1;
    do_branch(32'h100);
    repeat (20) step();

    // fill with consumer stalled, then a single pop reopens issue
    ready_i = 1'b0;
    do_branch(32'h100);
    repeat (20) step();
    chk("fill_occ", occupancy_o, FD);
    chk("fill_req", instr_req_o, 0);
    chk("fill_busy", busy_o, 0);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("resume_req", instr_req_o, 1);
    chk("resume_addr", instr_addr_o, 32'h10C);
    ready_i = 1'b1;
    repeat (15) step();

    // halfword-aligned target
    do_branch(32'h202);
    repeat (15) step();

    // redirect with responses in flight
    rv_pct = 0;
    do_branch(32'h300);
    repeat (4) step();
    chk("inflight_busy", busy_o, 1);
    rv_pct = 100;
    do_branch(32'h400);
    for (int i = 0; i < 20 && !valid_o; i++) step();
    chk("b400_valid", valid_o, 1);
    chk("b400_addr", addr_o, 32'h400);
    chk("b400_data", rdata_o, mem_word(32'h400));
    repeat (10) step();

    // redirect while a request is held ungranted
    gnt_force_low = 1'b1;
    do_branch(32'h10);
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", instr_req_o, 1);
      chk("hold_addr", instr_addr_o, 32'h10);
      step();
    end
    do_branch(32'h500);
    chk("hold_after_br", instr_addr_o, 32'h10);
    grant_log.delete();
    gnt_force_low = 1'b0;
    repeat (12) step();
    chk("pend_grants", grant_log.size() >= 2, 1);
    if (grant_log.size() >= 2) begin
      chk("pend_first", grant_log[0], 32'h10);
      chk("pend_next", grant_log[1], 32'h500);
    end

    // stop on error at 0x20, resume on branch
    grant_log.delete();
    do_branch(32'h18);
    repeat (30) step();
    chk("stop_req", instr_req_o, 0);
    chk("stop_busy", busy_o, 0);
    chk("stop_drained", valid_o, 0);
    chk("stop_grants_max", grant_log.size() <= 3 + NR, 1);
    chk("stop_grants_min", grant_log.size() >= 3, 1);
    grant_log.delete();
    do_branch(32'h40);
    repeat (8) step();
    chk("resume_grants", grant_log.size() > 0, 1);
    if (grant_log.size() > 0) chk("resume_first", grant_log[0], 32'h40);

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      gnt_pct = $urandom_range(30, 100);
      rv_pct  = $urandom_range(20, 100);
      req_i   = 1'b1;
      ready_i = ($urandom_range(0, 99) < 70);
      do_branch($urandom & 32'h0000_FFFE);
      len = $urandom_range(5, 50);
      repeat (len) begin
        ready_i = ($urandom_range(0, 99) < 70);
        req_i   = ($urandom_range(0, 99) < 90);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
